// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing: an even-parity bit follows data bit 7.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clk,
    input  logic       rst,
    input  logic       i_UART_RX,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    input  logic       i_Ready,
    output logic       o_Frame_Err,
    output logic       o_Overrun,
    output logic       o_Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, rx_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          push, pop, wr_en, full, empty;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    assign rx_s  = sync2_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = o_Valid & i_Ready;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign wr_en = push & (~full | pop);
    assign ovr_d = push & full & ~pop;

    always_ff @(posedge i_Clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync1_q   <= i_UART_RX;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_ff @(posedge i_Clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        ferr_d    = 1'b0;
        push      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else cnt_d = cnt_q + 1'b1;
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end else cnt_d = cnt_q + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d     = '0;
                    par_err_d = ^{shift_q, rx_s};
                    state_d   = STOP;
                end else cnt_d = cnt_q + 1'b1;
            end
`endif
            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HI;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_err_q) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                    end
`endif
                    else begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end
                end else cnt_d = cnt_q + 1'b1;
            end
            // Hold off after a bad stop until the line recovers (break / stuck-low).
            WAIT_HI: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_Busy      = (state_q != IDLE);
        o_Valid     = ~empty;
        o_Data      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
        o_Frame_Err = ferr_q;
        o_Overrun   = ovr_q;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table plus FIFO/reset corner sequences.
module tb_uart_rx_fifo;
    localparam int CPB   = 64;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Edge (counted from the posedge before the start bit) on which the byte is pushed:
    // 2 sync flops + IDLE detect, half start bit, data/parity bits, full stop bit.
    localparam int PUSH_EDGE = 3 + CPB / 2 + (8 + PAR_BITS) * CPB + CPB;

    logic       clk = 1'b0;
    logic       rst, rx, ready;
    logic [7:0] data;
    logic       valid, ferr, ovr, busy;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clk(clk), .rst(rst), .i_UART_RX(rx), .o_Data(data), .o_Valid(valid),
        .i_Ready(ready), .o_Frame_Err(ferr), .o_Overrun(ovr), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_after;
        int         idle_after;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         n_checks = 0, n_fail = 0;
    int         pop_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
    logic       busy_seen = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;
    int         p0, f0, o0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard side: every accepted byte must match the oldest expected byte.
    always @(negedge clk) begin
        if (valid && ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h, expected no byte", data);
            end else chk("pop_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
        if (ferr) begin
            ferr_cnt++;
            chk("ferr_one_cycle", {31'd0, prev_ferr}, 32'd0);
        end
        if (ovr) begin
            ovr_cnt++;
            chk("ovr_one_cycle", {31'd0, prev_ovr}, 32'd0);
        end
        if (ferr || ovr) chk("flags_exclusive", {31'd0, ferr & ovr}, 32'd0);
        if (busy) busy_seen = 1'b1;
        prev_ferr = ferr;
        prev_ovr  = ovr;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop);
    endtask

    task automatic snap();
        p0 = pop_cnt;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
    endtask

    initial begin
        vecs[0] = '{8'hC3, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[2] = '{8'h99, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[3] = '{8'hB3, 1'b1, 0, 1, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 2, 1, 1'b0, 1'b1};
        vecs[5] = '{8'hA5, 1'b1, 0, 1, 1'b1, 1'b0};

        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        tick(3);
        chk("rst_data",  {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ferr",  {31'd0, ferr}, 32'd0);
        chk("rst_ovr",   {31'd0, ovr}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick(4);

        // Back-to-back good frames, a framing error with a held-low line, then recovery.
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            snap();
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            for (int k = 0; k < vecs[i].low_after; k++) drive_bit(1'b0);
            for (int k = 0; k < vecs[i].idle_after; k++) drive_bit(1'b1);
            chk($sformatf("vec%0d_pops", i), pop_cnt - p0, {31'd0, vecs[i].exp_push});
            chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, {31'd0, vecs[i].exp_ferr});
            chk($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 32'd0);
        end
        tick(CPB);
        chk("table_idle_busy", {31'd0, busy}, 32'd0);
        chk("table_q_empty", exp_q.size(), 32'd0);

        // Short low glitch: start is rejected at the half-bit resample.
        snap();
        busy_seen = 1'b0;
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(2 * CPB);
        chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        chk("glitch_busy_end", {31'd0, busy}, 32'd0);
        chk("glitch_valid", {31'd0, valid}, 32'd0);
        chk("glitch_pops", pop_cnt - p0, 32'd0);
        chk("glitch_ferr", ferr_cnt - f0, 32'd0);

        // Overrun: five bytes into a four-deep FIFO with the consumer stalled.
        ready = 1'b0;
        snap();
        for (int d = 1; d <= 5; d++) begin
            if (d <= DEPTH) exp_q.push_back(8'(d));
            send_frame(8'(d), 1'b1);
        end
        tick(2);
        chk("ovr_valid", {31'd0, valid}, 32'd1);
        chk("ovr_head", {24'd0, data}, 32'h01);
        chk("ovr_count", ovr_cnt - o0, 32'd1);
        chk("ovr_ferr", ferr_cnt - f0, 32'd0);
        ready = 1'b1;
        tick(10);
        chk("ovr_drain_pops", pop_cnt - p0, 32'd4);
        chk("ovr_drain_valid", {31'd0, valid}, 32'd0);
        chk("ovr_q_empty", exp_q.size(), 32'd0);

        // Full FIFO popped exactly on the stop-sample cycle of a fifth byte.
        ready = 1'b0;
        snap();
        exp_q.push_back(8'h11); send_frame(8'h11, 1'b1);
        exp_q.push_back(8'h22); send_frame(8'h22, 1'b1);
        exp_q.push_back(8'h33); send_frame(8'h33, 1'b1);
        exp_q.push_back(8'h44); send_frame(8'h44, 1'b1);
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                tick(PUSH_EDGE - 1);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
            end
        join
        tick(2);
        chk("sim_ovr", ovr_cnt - o0, 32'd0);
        chk("sim_pops", pop_cnt - p0, 32'd1);
        chk("sim_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick(10);
        chk("sim_drain_pops", pop_cnt - p0, 32'd5);
        chk("sim_q_empty", exp_q.size(), 32'd0);

        // Reset in the middle of 0x99's data bits, then a clean 0x3C.
        snap();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rx = 1'b1;
        tick(CPB / 2);
        rst = 1'b1;
        tick(1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, valid}, 32'd0);
        rst = 1'b0;
        tick(CPB + CPB / 2);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1);
        chk("midrst_pops", pop_cnt - p0, 32'd1);
        chk("midrst_ferr", ferr_cnt - f0, 32'd0);
        chk("midrst_q_empty", exp_q.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Wrong parity with a good stop bit: flagged, nothing delivered.
        snap();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(vecs[0].data[i] ^ 1'b0 ? 1'b0 : 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        snap();
        begin
            logic [7:0] bad;
            bad = 8'h3C;
            drive_bit(1'b0);
            for (int i = 0; i < 8; i++) drive_bit(bad[i]);
            drive_bit(~(^bad));
            drive_bit(1'b1);
            drive_bit(1'b1);
        end
        chk("par_ferr", ferr_cnt - f0, 32'd1);
        chk("par_pops", pop_cnt - p0, 32'd0);
        chk("par_valid", {31'd0, valid}, 32'd0);
`endif

        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
